// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, multi-cycle instruction-memory writes
// for stores into the IM window, post-write IF/ID flush and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned          ADDR_W       = 16,
  parameter int unsigned          DATA_W       = 16,
  parameter int unsigned          IDX_W        = 4,
  parameter logic [ADDR_W-1:0]    IM_BASE      = 16'h4000,
  parameter logic [ADDR_W-1:0]    IM_LIMIT     = 16'h8000,
  parameter int unsigned          IM_WR_CYCLES = 2,
  parameter int unsigned          PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoReg1,
  input  logic [IDX_W-1:0]  RegWriteIndex1,
  input  logic [IDX_W-1:0]  RegReadIndex10,
  input  logic [IDX_W-1:0]  RegReadIndex20,
  input  logic [ADDR_W-1:0] Result1,
  input  logic [DATA_W-1:0] DataIn1,
  input  logic              MemWrite1,
  output logic              Pause,
  output logic              Flush,
  output logic [ADDR_W-1:0] ImWriteAddr,
  output logic [DATA_W-1:0] ImWriteData,
  output logic              ImWrite,
  output logic [PERF_W-1:0] StallCount
);

  localparam int unsigned CntW = (IM_WR_CYCLES > 1) ? $clog2(IM_WR_CYCLES) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(IM_WR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StFlush} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                im_write_q, im_write_d;
  logic                flush_q, flush_d;
  logic [PERF_W-1:0]   stall_q, stall_d;

  logic imreq;
  logic lu;
  logic pause_raw;

  assign imreq = MemWrite1 && (Result1 >= IM_BASE) && (Result1 < IM_LIMIT);
  assign lu    = MemtoReg1 &&
                 ((RegWriteIndex1 == RegReadIndex10) || (RegWriteIndex1 == RegReadIndex20));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    pause_raw = 1'b0;
    case (state_q)
      StIdle, StFlush: begin
        if (imreq) begin
          pause_raw = 1'b1;
          addr_d    = Result1;
          data_d    = DataIn1;
          cnt_d     = CntReload;
          state_d   = StWrite;
        end else begin
          pause_raw = lu;
          state_d   = StIdle;
        end
      end
      StWrite: begin
        // Last write cycle lets the store retire unless a load-use stall coincides.
        if (cnt_q != '0) begin
          pause_raw = 1'b1;
          cnt_d     = cnt_q - CntW'(1);
        end else begin
          pause_raw = lu;
          state_d   = StFlush;
        end
      end
      default: state_d = StIdle;
    endcase

    Pause      = rst && pause_raw;
    im_write_d = (state_d == StWrite);
    flush_d    = (state_d == StFlush);
    stall_d    = (Pause && (stall_q != '1)) ? stall_q + PERF_W'(1) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      im_write_q <= 1'b0;
      flush_q    <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      im_write_q <= im_write_d;
      flush_q    <= flush_d;
      stall_q    <= stall_d;
    end
  end

  assign Flush       = rst && flush_q;
  assign ImWrite     = im_write_q;
  assign ImWriteAddr = addr_q;
  assign ImWriteData = data_q;
  assign StallCount  = stall_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 16-bit five-stage CPU.
- Raises a combinational load-use stall.
- Detects MEM-stage stores that fall in the instruction-memory window and runs them as multi-cycle IM writes over the shared bus, stalling the pipeline while the write runs.
- Issues a one-cycle IF/ID flush after each IM write so a stale fetched instruction is discarded.
- Counts stall cycles for performance measurement.

Parameters:
ADDR_W, 16, address/result width
DATA_W, 16, store data width
IDX_W, 4, register index width
IM_BASE, 16'h4000, inclusive lower bound of IM write window
IM_LIMIT, 16'h8000, exclusive upper bound of IM write window
IM_WR_CYCLES, 2, bus cycles ImWrite is held per store; legal values >= 1
PERF_W, 16, stall counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
MemtoReg1  in  1  EX/MEM instruction is a load
RegWriteIndex1  in  IDX_W  destination register of the EX/MEM instruction
RegReadIndex10  in  IDX_W  first source register of the ID/EX instruction
RegReadIndex20  in  IDX_W  second source register of the ID/EX instruction
Result1  in  ADDR_W  EX/MEM address
DataIn1  in  DATA_W  EX/MEM store data
MemWrite1  in  1  EX/MEM instruction is a store
Pause  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
Flush  out  1  turn IF/ID into a bubble and refetch
ImWriteAddr  out  ADDR_W  IM write address (registered)
ImWriteData  out  DATA_W  IM write data (registered)
ImWrite  out  1  IM write strobe (registered)
StallCount  out  PERF_W  saturating count of cycles with Pause=1

Behaviour:
- imreq = MemWrite1 && (Result1 >= IM_BASE) && (Result1 < IM_LIMIT), unsigned compare.
- lu = MemtoReg1 && (RegWriteIndex1 == RegReadIndex10 || RegWriteIndex1 == RegReadIndex20). lu is combinational, same cycle, and there is no register-0 exemption.
- State machine states: IDLE, WRITE, FLUSH. The state register and the 0..IM_WR_CYCLES-1 down-counter cnt update on the rising edge.
- IDLE:
  - If imreq: Pause=1, latch Result1/DataIn1, cnt<=IM_WR_CYCLES-1, next state WRITE.
  - Otherwise Pause=lu.
- WRITE:
  - ImWrite=1; ImWriteAddr/ImWriteData come from the latch. They stay stable for the whole state and ignore input changes.
  - While cnt!=0: Pause=1 and cnt decrements.
  - When cnt==0: Pause=lu, so the store can retire this cycle unless a load-use stall is also present. Next state FLUSH.
  - imreq is ignored inside WRITE; the presented store is the one already latched.
- FLUSH:
  - Flush=1 for exactly this cycle. ImWrite=0.
  - If imreq, a back-to-back IM store: Pause=1, capture it as in IDLE, next state WRITE. Flush stays 1 this cycle.
  - Otherwise Pause=lu, next state IDLE.
- Pause in IDLE is fully combinational, with zero latency from the inputs. ImWrite, ImWriteAddr, ImWriteData and Flush are functions of registered state only.
- Latency: an IM store seen in cycle 0 puts ImWrite high in cycles 1..IM_WR_CYCLES and Flush high in cycle IM_WR_CYCLES+1.
- StallCount increments by 1 on each rising edge where Pause=1 and rst=1. It saturates at all-ones with no wrap.
- Reset (rst=0 at an edge): state<=IDLE, cnt<=0, latch<=0, StallCount<=0.
  - While rst=0, Pause=0 and Flush=0.
  - Registered outputs reset to 0: ImWrite=0, ImWriteAddr=0, ImWriteData=0.
  - Reset during WRITE aborts the write: ImWrite is low in the cycle after the reset edge, and no FLUSH follows.
- Window boundaries: Result1=IM_BASE is in the window. Result1=IM_LIMIT and Result1=IM_BASE-1 are out of the window and treated as normal data-memory stores (no stall from the window logic).
- A load whose address is in the window does not trigger an IM write. It can still raise lu.

Test Plan:
- Load-use: MemtoReg1=1, RegWriteIndex1=3, RegReadIndex20=3, no store -> Pause=1 in the same cycle, ImWrite=0, StallCount +1. Changing RegReadIndex20 to 4 -> Pause=0.
- IM store, IM_WR_CYCLES=2: Result1=16'h4000, DataIn1=16'hBEEF, MemWrite1=1 held -> Pause 1,1,0 in cycles 0..2; ImWrite=1 with addr 4000/data BEEF in cycles 1..2; Flush=1 in cycle 3; StallCount=2.
- Window boundaries: store to 16'h3FFF and to 16'h8000 -> Pause=0, ImWrite never asserted. Store to 16'h7FFF -> full IM write sequence.
- Back-to-back: a second IM store (16'h4010, 16'h1234) presented during the FLUSH cycle -> Flush=1 and Pause=1 in that cycle, ImWrite=1 with addr 4010 for the next 2 cycles, then a second Flush.
- Reset mid-write: rst=0 in cycle 1 of a write -> the next cycle has ImWrite=0, Flush=0, Pause=0, StallCount=0, and no Flush occurs after reset is released.
- Saturation: PERF_W=4, hold lu for 20 cycles -> StallCount stops at 15.
